// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard / forwarding controller.
package pipe_pkg;

    // Default register index width; the scoreboard entry rd field uses it.
    localparam int DEF_REG_AW = 5;

    // Forwarding select value meaning "take the register-file value".
    localparam int FWD_RF = 0;

    // One scoreboard slot per post-decode stage.
    typedef struct packed {
        logic                  v;
        logic [DEF_REG_AW-1:0] rd;
        logic                  we;
        logic                  ld;
    } sb_entry_t;

endpackage

// File: rtl/pipe_fwd_match.sv
// Priority matcher for one source operand against the stage scoreboard.
// The youngest writing producer (lowest stage index) decides the result:
// a load that cannot forward yet raises a hazard, anything else forwards.
module pipe_fwd_match
    import pipe_pkg::*;
#(
    parameter int REG_AW     = DEF_REG_AW,
    parameter int NSTAGE     = 3,
    parameter int LOAD_STAGE = 1,
    parameter int SEL_W      = $clog2(NSTAGE + 1)
) (
    input  logic [REG_AW-1:0]        src,
    input  logic                     used,
    input  logic [NSTAGE-1:0]        sb_v,
    input  logic [NSTAGE-1:0]        sb_we,
    input  logic [NSTAGE-1:0]        sb_ld,
    input  logic [NSTAGE*REG_AW-1:0] sb_rd,
    output logic                     hazard,
    output logic [SEL_W-1:0]         sel
);

    // Scan oldest to youngest so the youngest matching stage is assigned last.
    always_comb begin
        hazard = 1'b0;
        sel    = SEL_W'(FWD_RF);
        if (used && (src != '0)) begin
            for (int k = NSTAGE - 1; k >= 0; k--) begin
                if (sb_v[k] && sb_we[k] &&
                    (sb_rd[k*REG_AW +: REG_AW] != '0) &&
                    (sb_rd[k*REG_AW +: REG_AW] == src)) begin
                    if ((k < LOAD_STAGE) && sb_ld[k]) begin
                        hazard = 1'b1;
                        sel    = SEL_W'(FWD_RF);
                    end else begin
                        hazard = 1'b0;
                        sel    = SEL_W'(k + 1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the in-order pipeline.
// Tracks destination registers of the NSTAGE post-decode stages in a shift
// register scoreboard and derives forwarding selects, load-use stall and
// branch flush. Optional performance counters: PIPE_HAZARD_PERF_EN.
// The scoreboard rd field is DEF_REG_AW wide, so REG_AW is expected to
// stay at that default.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int  REG_AW     = DEF_REG_AW,
    parameter int  NSTAGE     = 3,
    parameter int  LOAD_STAGE = 1,
    localparam int SEL_W      = $clog2(NSTAGE + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rf_we,
    input  logic              id_is_load,
    input  logic              br_taken,
    output logic              issue,
    output logic              stall,
    output logic              flush,
    output logic [SEL_W-1:0]  fwd1_sel,
    output logic [SEL_W-1:0]  fwd2_sel,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_cycles
);

    sb_entry_t sb_reg [NSTAGE];

    logic [NSTAGE-1:0]        sb_v;
    logic [NSTAGE-1:0]        sb_we;
    logic [NSTAGE-1:0]        sb_ld;
    logic [NSTAGE*REG_AW-1:0] sb_rd;

    logic             haz1;
    logic             haz2;
    logic [SEL_W-1:0] sel1;
    logic [SEL_W-1:0] sel2;

    // Flatten the scoreboard fields for the matchers.
    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_flat
        assign sb_v[gi]                    = sb_reg[gi].v;
        assign sb_we[gi]                   = sb_reg[gi].we;
        assign sb_ld[gi]                   = sb_reg[gi].ld;
        assign sb_rd[gi*REG_AW +: REG_AW]  = sb_reg[gi].rd;
    end

    pipe_fwd_match #(
        .REG_AW     (REG_AW),
        .NSTAGE     (NSTAGE),
        .LOAD_STAGE (LOAD_STAGE),
        .SEL_W      (SEL_W)
    ) u_match_rs1 (
        .src    (id_rs1),
        .used   (id_rs1_used),
        .sb_v   (sb_v),
        .sb_we  (sb_we),
        .sb_ld  (sb_ld),
        .sb_rd  (sb_rd),
        .hazard (haz1),
        .sel    (sel1)
    );

    pipe_fwd_match #(
        .REG_AW     (REG_AW),
        .NSTAGE     (NSTAGE),
        .LOAD_STAGE (LOAD_STAGE),
        .SEL_W      (SEL_W)
    ) u_match_rs2 (
        .src    (id_rs2),
        .used   (id_rs2_used),
        .sb_v   (sb_v),
        .sb_we  (sb_we),
        .sb_ld  (sb_ld),
        .sb_rd  (sb_rd),
        .hazard (haz2),
        .sel    (sel2)
    );

    // Flush beats stall; everything is forced quiet while reset is held.
    assign flush    = br_taken & rst_n;
    assign stall    = rst_n & id_valid & (haz1 | haz2) & ~br_taken;
    assign issue    = rst_n & id_valid & ~stall & ~flush;
    assign fwd1_sel = rst_n ? sel1 : SEL_W'(FWD_RF);
    assign fwd2_sel = rst_n ? sel2 : SEL_W'(FWD_RF);

    // Scoreboard shift: issued instruction enters EX, otherwise a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTAGE; k++) begin
                sb_reg[k] <= '0;
            end
        end else begin
            if (issue) begin
                sb_reg[0] <= '{v: 1'b1, rd: id_rd, we: id_rf_we, ld: id_is_load};
            end else begin
                sb_reg[0] <= '0;
            end
            for (int k = 1; k < NSTAGE; k++) begin
                sb_reg[k] <= sb_reg[k-1];
            end
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (flush && (flush_cnt_reg != 32'hFFFF_FFFF)) begin
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cnt_reg;
    assign flush_cycles = flush_cnt_reg;
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed, table-driven bench for pipe_hazard_unit (default parameters).
module tb_pipe_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] id_rd;
    logic       id_rf_we;
    logic       id_is_load;
    logic       br_taken;
    logic       issue;
    logic       stall;
    logic       flush;
    logic [1:0] fwd1_sel;
    logic [1:0] fwd2_sel;
    logic [31:0] stall_cycles;
    logic [31:0] flush_cycles;

    pipe_hazard_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_rf_we     (id_rf_we),
        .id_is_load   (id_is_load),
        .br_taken     (br_taken),
        .issue        (issue),
        .stall        (stall),
        .flush        (flush),
        .fwd1_sel     (fwd1_sel),
        .fwd2_sel     (fwd2_sel),
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       br;
        logic       e_issue;
        logic       e_stall;
        logic       e_flush;
        logic [1:0] e_f1;
        logic [1:0] e_f2;
    } vec_t;

    vec_t vecs[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   exp_stalls = 0;
    int   exp_flushes = 0;

    task automatic add_vec(input logic v, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2,
                           input logic [4:0] rd, input logic we, input logic ld,
                           input logic br, input logic ei, input logic es,
                           input logic ef, input logic [1:0] f1, input logic [1:0] f2);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
        t.rd = rd; t.we = we; t.ld = ld; t.br = br;
        t.e_issue = ei; t.e_stall = es; t.e_flush = ef; t.e_f1 = f1; t.e_f2 = f2;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic we, input logic ld,
                         input logic br);
        id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_rf_we = we; id_is_load = ld; br_taken = br;
    endtask

    task automatic check_outs(input string tag, input logic ei, input logic es,
                              input logic ef, input logic [1:0] f1, input logic [1:0] f2);
        check({tag, " issue"}, {31'd0, issue}, {31'd0, ei});
        check({tag, " stall"}, {31'd0, stall}, {31'd0, es});
        check({tag, " flush"}, {31'd0, flush}, {31'd0, ef});
        check({tag, " fwd1"},  {30'd0, fwd1_sel}, {30'd0, f1});
        check({tag, " fwd2"},  {30'd0, fwd2_sel}, {30'd0, f2});
    endtask

    initial begin
        // v  rs1 u1 rs2 u2  rd we ld br | issue stall flush f1 f2
        add_vec(1,  1,1,  2,1,  5,1,0, 0,  1,0,0, 0,0); // add x5
        add_vec(1,  5,1,  0,1,  8,1,0, 0,  1,0,0, 1,0); // x5 in EX, x0 src
        add_vec(1,  5,1,  8,1,  0,1,0, 0,  1,0,0, 2,1); // x5 in MEM, x8 in EX; writes x0
        add_vec(1,  0,1,  5,1,  6,1,1, 0,  1,0,0, 0,3); // x0 in EX ignored; x5 in WB; lw x6
        add_vec(1,  5,1,  6,1, 10,1,0, 0,  0,1,0, 0,0); // load-use on x6
        add_vec(1,  5,1,  6,1, 10,1,0, 0,  1,0,0, 0,2); // after bubble, x6 from MEM
        add_vec(1,  0,0,  0,0,  7,1,0, 0,  1,0,0, 0,0); // add x7
        add_vec(1,  0,0,  0,0,  7,1,1, 0,  1,0,0, 0,0); // lw x7
        add_vec(1,  7,1,  0,0, 11,1,0, 0,  0,1,0, 0,0); // shadowed by younger load
        add_vec(1,  7,1,  0,0, 11,1,0, 0,  1,0,0, 2,0); // load value from MEM
        add_vec(1, 11,1,  0,0, 12,1,1, 0,  1,0,0, 1,0); // lw x12, reads x11 in EX
        add_vec(1, 12,1,  0,0, 14,1,0, 1,  0,0,1, 0,0); // branch beats load-use
        add_vec(1, 12,1, 14,1, 15,1,0, 0,  1,0,0, 2,0); // flushed x14 never entered
        add_vec(1, 15,1,  0,0, 16,1,0, 1,  0,0,1, 1,0); // flush 1 of 2
        add_vec(1, 15,1,  0,0, 16,1,0, 1,  0,0,1, 2,0); // flush 2 of 2
        add_vec(0, 15,1,  0,0, 16,1,0, 0,  0,0,0, 3,0); // WB forward, no valid ID
        add_vec(1,  0,0,  0,0, 20,1,1, 0,  1,0,0, 0,0); // lw x20
        add_vec(1, 20,0, 20,0,  0,0,0, 0,  1,0,0, 0,0); // unused sources never stall
        add_vec(1,  0,0, 20,1,  0,0,0, 0,  1,0,0, 0,2); // non-writing EX entry skipped
        add_vec(1, 20,1,  0,0,  0,0,0, 0,  1,0,0, 3,0); // load in WB forwards

        // Reset state with busy-looking inputs
        rst_n = 1'b0;
        drive(1, 5,1, 6,1, 7,1,1, 1);
        #2;
        check_outs("reset", 0,0,0, 0,0);
        check("reset stall_cycles", stall_cycles, 32'd0);
        check("reset flush_cycles", flush_cycles, 32'd0);
        $display("reset: issue=%0b stall=%0b flush=%0b", issue, stall, flush);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].rs1, vecs[i].u1, vecs[i].rs2, vecs[i].u2,
                  vecs[i].rd, vecs[i].we, vecs[i].ld, vecs[i].br);
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), vecs[i].e_issue, vecs[i].e_stall,
                       vecs[i].e_flush, vecs[i].e_f1, vecs[i].e_f2);
            $display("vec %0d: issue=%0b stall=%0b flush=%0b fwd1=%0d fwd2=%0d",
                     i, issue, stall, flush, fwd1_sel, fwd2_sel);
            if (vecs[i].e_stall) exp_stalls++;
            if (vecs[i].e_flush) exp_flushes++;
            @(posedge clk);
            #1;
        end

`ifdef PIPE_HAZARD_PERF_EN
        check("stall_cycles", stall_cycles, 32'(exp_stalls));
        check("flush_cycles", flush_cycles, 32'(exp_flushes));
`else
        check("stall_cycles", stall_cycles, 32'd0);
        check("flush_cycles", flush_cycles, 32'd0);
`endif
        $display("counters: stall_cycles=%0d flush_cycles=%0d", stall_cycles, flush_cycles);

        // Reset in the middle of a load-use stall
        drive(1, 0,0, 0,0, 21,1,1, 0);
        @(posedge clk);
        #1;
        drive(1, 21,1, 0,0, 22,1,0, 0);
        #1;
        check("midrst pre stall", {31'd0, stall}, 32'd1);
        check("midrst pre issue", {31'd0, issue}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst stall", {31'd0, stall}, 32'd0);
        check("midrst issue", {31'd0, issue}, 32'd0);
        check("midrst stall_cycles", stall_cycles, 32'd0);
        check("midrst flush_cycles", flush_cycles, 32'd0);
        $display("mid-stall reset: stall=%0b issue=%0b", stall, issue);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_outs("post-reset", 1,0,0, 0,0);
        $display("post-reset: issue=%0b stall=%0b fwd1=%0d", issue, stall, fwd1_sel);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
